// File: rtl/vga_sync_rx_if.sv
// Bundle between a VGA-style sync source and the timing receiver.
// Transfer qualifier: hsync/vsync are sampled only on clk edges where
// p_tick is high. p_tick is a one-clk enable, not a handshake, so there is
// no back-pressure. Every output changes only on a ticked edge, except the
// pulses, which clear on the next clk, and reset, which clears everything.
interface vga_sync_rx_if;
    logic       p_tick;
    logic       hsync;
    logic       vsync;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       locked;
    logic       frame_start;
    logic       line_err;
    logic       frame_err;
    logic [7:0] frame_count;
    logic [1:0] state_dbg;

    modport master (
        output p_tick, hsync, vsync,
        input  pix_x, pix_y, video_on, locked, frame_start,
        input  line_err, frame_err, frame_count, state_dbg
    );

    modport slave (
        input  p_tick, hsync, vsync,
        output pix_x, pix_y, video_on, locked, frame_start,
        output line_err, frame_err, frame_count, state_dbg
    );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA timing receiver: locks onto incoming hsync/vsync, rebuilds the pixel
// position, and reports line/frame timing violations once it has locked.
module vga_sync_rx #(
    parameter int H_DISP     = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_DISP     = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int LOCK_LINES = 4
) (
    input logic          clk,
    input logic          reset,
    vga_sync_rx_if.slave bus
);
    localparam int GW = $clog2(LOCK_LINES + 1);
    localparam logic [9:0] H_LAST   = 10'(H_DISP + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_DISP + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_DISP);
    localparam logic [9:0] V_VIS    = 10'(V_DISP);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_LINES);

    typedef enum logic [1:0] {SEARCH, H_TRACK, V_TRACK, LOCKED} state_t;

    state_t        state, state_nx;
    logic [9:0]    h_cnt, v_cnt, h_inc, v_inc, h_nx, v_nx;
    logic [GW-1:0] good, good_nx;
    logic [7:0]    fc, fc_nx;
    logic          vseen, vseen_nx;
    logic          hs_q, vs_q, hs_fall, vs_fall, h_wrap;
    logic          exp_hs, exp_vs;
    logic          fs_q, le_q, fe_q, fs_nx, le_nx, fe_nx;

    // Free-running position prediction and sync edge detection for this tick.
    always_comb begin
        h_wrap  = (h_cnt == H_LAST);
        h_inc   = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_inc   = !h_wrap ? v_cnt : ((v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1);
        hs_fall = !bus.hsync && hs_q;
        vs_fall = !bus.vsync && vs_q;
        exp_hs  = !((h_inc >= HS_START) && (h_inc < HS_END));
        exp_vs  = !((v_inc >= VS_START) && (v_inc < VS_END));
    end

    // Lock FSM: next state, counter loads and pulses, assuming a tick occurs.
    always_comb begin
        state_nx = state;
        h_nx     = h_inc;
        v_nx     = v_inc;
        good_nx  = good;
        vseen_nx = vseen;
        fc_nx    = fc;
        fs_nx    = 1'b0;
        le_nx    = 1'b0;
        fe_nx    = 1'b0;
        case (state)
            SEARCH: begin
                if (hs_fall) begin
                    h_nx     = HS_START;
                    good_nx  = '0;
                    state_nx = H_TRACK;
                end
            end
            H_TRACK: begin
                if (hs_fall) begin
                    if (h_inc == HS_START) begin
                        good_nx = good + GW'(1);
                        if (good_nx == GOOD_LOCK) begin
                            state_nx = V_TRACK;
                            vseen_nx = 1'b0;
                        end
                    end else begin
                        good_nx = '0;
                        h_nx    = HS_START;
                    end
                end
            end
            V_TRACK: begin
                if (hs_fall && (h_inc != HS_START)) begin
                    state_nx = SEARCH;
                end else if (vs_fall) begin
                    if (!vseen) begin
                        v_nx     = VS_START;
                        vseen_nx = 1'b1;
                    end else if (v_inc == VS_START) begin
                        state_nx = LOCKED;
                        fc_nx    = 8'd0;
                    end else begin
                        v_nx = VS_START;
                    end
                end
            end
            LOCKED: begin
                // A simultaneous h and v mismatch is reported as a line error.
                if (bus.hsync != exp_hs) begin
                    le_nx    = 1'b1;
                    state_nx = SEARCH;
                end else if (bus.vsync != exp_vs) begin
                    fe_nx    = 1'b1;
                    state_nx = SEARCH;
                end else if ((h_inc == 10'd0) && (v_inc == 10'd0)) begin
                    fs_nx = 1'b1;
                    fc_nx = fc + 8'd1;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    // State and counters advance only on p_tick; pulses clear every clk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SEARCH;
            h_cnt <= '0;
            v_cnt <= '0;
            good  <= '0;
            vseen <= 1'b0;
            fc    <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
            le_q  <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            le_q <= 1'b0;
            fe_q <= 1'b0;
            if (bus.p_tick) begin
                state <= state_nx;
                h_cnt <= h_nx;
                v_cnt <= v_nx;
                good  <= good_nx;
                vseen <= vseen_nx;
                fc    <= fc_nx;
                hs_q  <= bus.hsync;
                vs_q  <= bus.vsync;
                fs_q  <= fs_nx;
                le_q  <= le_nx;
                fe_q  <= fe_nx;
            end
        end
    end

    assign bus.pix_x       = h_cnt;
    assign bus.pix_y       = v_cnt;
    assign bus.locked      = (state == LOCKED);
    assign bus.video_on    = (state == LOCKED) && (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign bus.frame_start = fs_q;
    assign bus.line_err    = le_q;
    assign bus.frame_err   = fe_q;
    assign bus.frame_count = fc;
    assign bus.state_dbg   = state;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx using a scaled-down raster (12x9 total) so that
// hundreds of frames fit in a short run.
module tb_vga_sync_rx;
    localparam int HD = 6, HF = 2, HSW = 2, HB = 2;
    localparam int VD = 4, VF = 1, VSW = 2, VB = 2, LL = 4;
    localparam int HT = HD + HF + HSW + HB;   // 12
    localparam int VT = VD + VF + VSW + VB;   // 9
    localparam int HSS = HD + HF;             // 8
    localparam int VSS = VD + VF;             // 5
    localparam int FRAME = HT * VT;           // 108
    localparam int M_SEARCH = 0, M_HTRACK = 1, M_VTRACK = 2, M_LOCKED = 3;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vga_sync_rx_if bus();
    vga_sync_rx #(
        .H_DISP(HD), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_DISP(VD), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .LOCK_LINES(LL)
    ) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0, n_pass = 0;
    bit chk_en = 0, pin_pos = 0, ticked = 0;
    int n_ticks = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // transmitter
    int tx_h = 0, tx_v = 0, tx_line = 0, tx_htot = HT, tx_vsw = VSW, kill_line = -1;
    bit noise = 0;

    function automatic bit in_win(input int x, input int s, input int w);
        return (x >= s) && (x < s + w);
    endfunction

    function automatic bit tx_hs_now();
        if (noise) return 1'($urandom_range(0, 1));
        return !(in_win(tx_h, HSS, HSW) && (tx_line != kill_line));
    endfunction

    function automatic bit tx_vs_now();
        if (noise) return 1'($urandom_range(0, 1));
        return !in_win(tx_v, VSS, tx_vsw);
    endfunction

    task automatic tx_adv();
        tx_h++;
        if (tx_h >= tx_htot) begin
            tx_h = 0;
            tx_line++;
            tx_v = (tx_v + 1) % VT;
        end
    endtask

    // reference model
    int m_mode, m_h, m_v, m_good, m_fc;
    bit m_vseen, m_hsq, m_vsq, m_fs, m_le, m_fe;
    logic [7:0] exp_q[$];

    task automatic model_reset();
        m_mode = M_SEARCH; m_h = 0; m_v = 0; m_good = 0; m_fc = 0;
        m_vseen = 0; m_hsq = 1; m_vsq = 1; m_fs = 0; m_le = 0; m_fe = 0;
        exp_q.delete();
    endtask

    task automatic model_tick(input bit hs, input bit vs);
        bit fh, fv;
        int nh, nv;
        fh = !hs && m_hsq;
        fv = !vs && m_vsq;
        m_hsq = hs;
        m_vsq = vs;
        nh = (m_h + 1) % HT;
        nv = (m_h == HT - 1) ? (m_v + 1) % VT : m_v;
        if (m_mode == M_SEARCH) begin
            if (fh) begin nh = HSS; m_good = 0; m_mode = M_HTRACK; end
        end else if (m_mode == M_HTRACK) begin
            if (fh && nh == HSS) begin
                m_good++;
                if (m_good == LL) begin m_mode = M_VTRACK; m_vseen = 0; end
            end else if (fh) begin
                m_good = 0; nh = HSS;
            end
        end else if (m_mode == M_VTRACK) begin
            if (fh && nh != HSS) m_mode = M_SEARCH;
            else if (fv && !m_vseen) begin nv = VSS; m_vseen = 1; end
            else if (fv && nv == VSS) begin m_mode = M_LOCKED; m_fc = 0; end
            else if (fv) nv = VSS;
        end else begin
            if (hs != !in_win(nh, HSS, HSW)) begin m_le = 1; m_mode = M_SEARCH; end
            else if (vs != !in_win(nv, VSS, VSW)) begin m_fe = 1; m_mode = M_SEARCH; end
            else if (nh == 0 && nv == 0) begin
                m_fs = 1;
                m_fc = (m_fc + 1) % 256;
                exp_q.push_back(8'(m_fc));
            end
        end
        m_h = nh;
        m_v = nv;
    endtask

    // driver tasks: inputs change at negedge, model follows each posedge
    task automatic cyc(input bit tk, input bit rn);
        bit hs, vs;
        hs = tx_hs_now();
        vs = tx_vs_now();
        bus.p_tick = tk; bus.hsync = hs; bus.vsync = vs; reset = rn;
        @(posedge clk);
        ticked = 0;
        if (!rn) model_reset();
        else begin
            m_fs = 0; m_le = 0; m_fe = 0;
            if (tk) begin model_tick(hs, vs); tx_adv(); n_ticks++; ticked = 1; end
        end
        @(negedge clk);
    endtask

    task automatic tick2(input int n);
        for (int i = 0; i < n; i++) begin cyc(0, 1); cyc(1, 1); end
    endtask

    task automatic tickr(input int n, input int gmax);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gmax)) cyc(0, 1);
            cyc(1, 1);
        end
    endtask

    // scoreboard: cycle compare against model plus event-level pins
    int tick_since = 0, vid_cnt = 0, n_le = 0, n_fe = 0, last_fc = 0;
    bit fs_valid = 0, saw_wrap = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pix_x", int'(bus.pix_x), m_h);
            chk("pix_y", int'(bus.pix_y), m_v);
            chk("locked", int'(bus.locked), int'(m_mode == M_LOCKED));
            chk("video_on", int'(bus.video_on), int'(m_mode == M_LOCKED && m_h < HD && m_v < VD));
            chk("frame_start", int'(bus.frame_start), int'(m_fs));
            chk("line_err", int'(bus.line_err), int'(m_le));
            chk("frame_err", int'(bus.frame_err), int'(m_fe));
            chk("frame_count", int'(bus.frame_count), m_fc);
            if (bus.line_err) n_le++;
            if (bus.frame_err) n_fe++;
            if (bus.line_err && pin_pos) chk("line_err_at_hs_start", int'(bus.pix_x), HSS);
            if (bus.frame_err && pin_pos) begin
                chk("frame_err_row", int'(bus.pix_y), VSS + VSW);
                chk("frame_err_col", int'(bus.pix_x), 0);
            end
            if (!bus.locked) fs_valid = 0;
            if (bus.frame_start) begin
                if (exp_q.size() == 0) chk("frame_start_expected", 1, 0);
                else chk("fs_frame_count", int'(bus.frame_count), int'(exp_q.pop_front()));
                if (fs_valid) begin
                    chk("frame_period_ticks", tick_since, FRAME);
                    chk("video_ticks_per_frame", vid_cnt, HD * VD);
                end
                if (bus.frame_count == 8'd0 && last_fc == 255) saw_wrap = 1;
                last_fc = int'(bus.frame_count);
                tick_since = 0; vid_cnt = 0; fs_valid = 1;
            end
            if (ticked) begin
                tick_since++;
                if (bus.video_on) vid_cnt++;
            end
        end
    end

    initial begin
        logic [9:0] s_x, s_y;
        logic [7:0] s_fc;
        bit got, saw_lock;
        int le0, fe0;

        bus.p_tick = 0; bus.hsync = 1; bus.vsync = 1;
        model_reset();
        @(negedge clk);
        repeat (3) cyc(0, 0);
        chk_en = 1;
        cyc(0, 0);
        chk("reset_pix", int'({bus.pix_y, bus.pix_x}), 0);
        chk("reset_flags", int'({bus.frame_count, bus.video_on, bus.locked,
                                 bus.frame_start, bus.line_err, bus.frame_err}), 0);

        // clean stream from (0,0), p_tick every 2nd clk
        tx_h = 0; tx_v = 0; tx_line = 0; n_ticks = 0;
        cyc(0, 1);
        for (int i = 0; i < 4 * FRAME; i++) begin
            cyc(1, 1);
            if (bus.locked) break;
            cyc(0, 1);
        end
        chk("lock_after_ticks", n_ticks, 169);
        chk("lock_pix_x", int'(bus.pix_x), 0);
        chk("lock_pix_y", int'(bus.pix_y), VSS);
        tick2(3 * FRAME);
        chk("frame_count_after_3", int'(bus.frame_count), 3);

        // one suppressed hsync pulse
        pin_pos = 1;
        kill_line = tx_line + 1;
        got = 0;
        for (int i = 0; i < 3 * HT && !got; i++) begin
            tick2(1);
            got = bus.line_err;
        end
        chk("line_err_seen", int'(got), 1);
        chk("line_err_drops_lock", int'(bus.locked), 0);
        kill_line = -1;
        for (int i = 0; i < 3 * FRAME && !bus.locked; i++) tick2(1);
        chk("relock_after_line_err", int'(bus.locked), 1);

        // one 3-line vsync pulse
        for (int i = 0; i < FRAME && !(tx_h == 0 && tx_v == 0); i++) tick2(1);
        tx_vsw = 3;
        got = 0;
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            tick2(1);
            got = bus.frame_err;
        end
        tx_vsw = VSW;
        chk("frame_err_seen", int'(got), 1);
        chk("frame_err_drops_lock", int'(bus.locked), 0);
        for (int i = 0; i < 3 * FRAME && !bus.locked; i++) tick2(1);
        chk("relock_after_frame_err", int'(bus.locked), 1);
        pin_pos = 0;

        // no tick for 1000 clks: nothing moves
        tickr(37, 1);
        s_x = bus.pix_x; s_y = bus.pix_y; s_fc = bus.frame_count;
        repeat (1000) cyc(0, 1);
        chk("idle_pix_x", int'(bus.pix_x), int'(s_x));
        chk("idle_pix_y", int'(bus.pix_y), int'(s_y));
        chk("idle_frame_count", int'(bus.frame_count), int'(s_fc));
        chk("idle_locked", int'(bus.locked), 1);

        // reset mid-frame while locked
        cyc(0, 0);
        chk("midreset_pix", int'({bus.pix_y, bus.pix_x}), 0);
        chk("midreset_flags", int'({bus.frame_count, bus.video_on, bus.locked,
                                    bus.frame_start, bus.line_err, bus.frame_err}), 0);
        cyc(0, 1);

        // lines one pixel too long: never locks, never flags
        tx_htot = HT + 1;
        tx_h = $urandom_range(0, HT);
        tx_v = $urandom_range(0, VT - 1);
        le0 = n_le; fe0 = n_fe; saw_lock = 0;
        for (int i = 0; i < 3000; i++) begin
            tickr(1, 2);
            if (bus.locked) saw_lock = 1;
        end
        chk("long_lines_never_lock", int'(saw_lock), 0);
        chk("long_lines_no_line_err", n_le - le0, 0);
        tx_htot = HT;
        tx_h = tx_h % HT;

        // random sync noise, then clean stream again
        noise = 1;
        tickr(400, 2);
        noise = 0;

        // 257 locked frames with p_tick every clk: frame_count wraps
        for (int i = 0; i < 4 * FRAME && !bus.locked; i++) cyc(1, 1);
        chk("relock_after_noise", int'(bus.locked), 1);
        le0 = n_le; fe0 = n_fe; saw_wrap = 0;
        for (int i = 0; i < 257 * FRAME; i++) cyc(1, 1);
        chk("wrap_seen", int'(saw_wrap), 1);
        chk("frame_count_after_257", int'(bus.frame_count), 1);
        chk("long_run_no_line_err", n_le - le0, 0);
        chk("long_run_no_frame_err", n_fe - fe0, 0);
        chk("long_run_still_locked", int'(bus.locked), 1);
        chk("fs_queue_drained", exp_q.size(), 0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receive-side counterpart of the 640x480 VGA timing generator. Samples incoming hsync/vsync on each pixel tick, locks to the timing, and rebuilds pixel_x/pixel_y, video_on and frame markers.
- Lets a capture or monitor path, or a loop-back checker on the board, follow any vga_sync-compatible stream.
- Flags line and frame timing violations and drops lock on any mismatch.

Parameters:
- H_DISP, 640, visible pixels per line
- H_FP, 16, pixels between display end and hsync start
- H_SYNC, 96, hsync pulse width (active low)
- H_BP, 48, pixels after hsync before next line
- V_DISP, 480, visible lines
- V_FP, 10, lines between display end and vsync start
- V_SYNC, 2, vsync pulse width in lines (active low)
- V_BP, 33, lines after vsync
- LOCK_LINES, 4, consecutive correct-length lines needed for H lock

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- p_tick  input  1  pixel enable, one clk wide; all sampling and counting happens only when high
- hsync  input  1  incoming horizontal sync, active low
- vsync  input  1  incoming vertical sync, active low
- pix_x  output  10  recovered column of the pixel sampled at the last tick
- pix_y  output  10  recovered row
- video_on  output  1  locked && pix_x<H_DISP && pix_y<V_DISP
- locked  output  1  high in LOCKED state
- frame_start  output  1  one-clk pulse when locked and counters become (0,0)
- line_err  output  1  one-clk pulse on hsync mismatch while locked
- frame_err  output  1  one-clk pulse on vsync mismatch while locked
- frame_count  output  8  frames completed while locked, wraps 255->0

Behaviour:
- Derived constants:
  - H_TOT = H_DISP+H_FP+H_SYNC+H_BP = 800
  - V_TOT = 525
  - HS_START = H_DISP+H_FP = 656
  - VS_START = 490
- Reset (reset==0 at a clk edge): all outputs 0, state SEARCH, counters 0, good-line counter 0, previous-sample registers hs_q/vs_q = 1.
- Ticks: with p_tick low nothing changes. Pulse outputs are cleared on every clk unless re-asserted.
- Edge detection: on each tick, hs_fall = (hsync==0 && hs_q==1) and vs_fall likewise; then hs_q/vs_q take the current samples.
- Free-running counters on each tick:
  - h_cnt = h_cnt+1 mod H_TOT.
  - When h_cnt wraps 799->0, v_cnt = v_cnt+1 mod V_TOT.
  - Explicit loads below take priority over increment.
  - pix_x/pix_y are the registered h_cnt/v_cnt; latency is one clk after the sampling tick.
- State SEARCH:
  - hs_fall -> load h_cnt=HS_START, good=0, go H_TRACK.
- State H_TRACK:
  - On hs_fall, if the incremented h_cnt would equal HS_START, good++; otherwise good=0 and h_cnt is reloaded to HS_START.
  - When good reaches LOCK_LINES -> V_TRACK.
- State V_TRACK:
  - A hs_fall at the wrong position returns to SEARCH.
  - First vs_fall loads v_cnt=VS_START and sets the vseen flag.
  - Next vs_fall: if the predicted v_cnt==VS_START -> LOCKED and frame_count=0. Otherwise reload and remain in V_TRACK.
- State LOCKED, on each tick:
  - Expected hsync = !(HS_START<=h_cnt<HS_START+H_SYNC); expected vsync = !(VS_START<=v_cnt<VS_START+V_SYNC), both using the post-update counters.
  - Sample != expected hsync -> line_err=1, go SEARCH.
  - Else sample != expected vsync -> frame_err=1, go SEARCH.
  - If both mismatch on the same tick, only line_err pulses.
  - Leaving LOCKED clears locked and video_on on the same clk. pix_x/pix_y keep counting.
- frame_start fires when, in LOCKED, counters transition to (0,0); frame_count increments on the same clk.
- Widths: counters are 10-bit, compares are unsigned, and no value exceeds 799.

Test Plan:
- Reference vga_sync stream with p_tick every 2nd clk:
  - locked rises after the 2nd vsync fall following H lock.
  - pix_x/pix_y then equal the transmitter counters delayed one tick.
  - video_on is high for exactly 307200 ticks per frame.
  - frame_start pulses once per 420000 ticks.
- Suppress one hsync pulse while locked -> line_err pulses exactly on the tick with h_cnt=656. locked falls the same clk, and relock occurs within 3 frames.
- Stream with 801-pixel lines -> stays in SEARCH/H_TRACK, locked never asserts, line_err never pulses.
- vsync 3 lines wide while locked -> frame_err on the tick where v_cnt=492, h_cnt=0; locked drops.
- Assert reset mid-frame while locked -> next clk all outputs 0. Hold p_tick=0 for 1000 clks -> no output changes.
- Run 256 locked frames -> frame_count goes 255->0 on frame_start with no error pulses.
